// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared state encoding and gate bit positions for the gate checker
package gate_chk_pkg;
  localparam int N_GATES = 7;
  localparam int G_NOT  = 0;
  localparam int G_AND  = 1;
  localparam int G_OR   = 2;
  localparam int G_NAND = 3;
  localparam int G_NOR  = 4;
  localparam int G_XOR  = 5;
  localparam int G_XNOR = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden outputs of the seven basic gates
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic               a,
  input  logic               b,
  output logic [N_GATES-1:0] expected_o
);
  always_comb begin
    expected_o         = '0;
    expected_o[G_NOT]  = ~a;
    expected_o[G_AND]  = a & b;
    expected_o[G_OR]   = a | b;
    expected_o[G_NAND] = ~(a & b);
    expected_o[G_NOR]  = ~(a | b);
    expected_o[G_XOR]  = a ^ b;
    expected_o[G_XNOR] = ~(a ^ b);
  end
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: compares returned gate outputs against the reference model
// over a run of N_SAMPLES accepted samples and reports errors, coverage and first failure.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int N_SAMPLES = 10,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               valid,
  input  logic               a,
  input  logic               b,
  input  logic               t,
  input  logic               u,
  input  logic               v,
  input  logic               w,
  input  logic               x,
  input  logic               y,
  input  logic               z,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   first_err_idx,
  output logic [N_GATES-1:0] first_err_vec,
  output logic [3:0]         cov
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, err_q, err_d, idx_q, idx_d;
  logic [N_GATES-1:0] vec_q, vec_d, expected, mask;
  logic [3:0]         cov_q, cov_d;
  logic               busy_q, done_q, pass_q, accept, has_err;
  gate_ref_model u_ref (.a(a), .b(b), .expected_o(expected));
  assign mask    = expected ^ {z, y, x, w, v, u, t};
  assign has_err = |mask;
  assign accept  = valid && state_q == RUN;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    cov_d   = cov_q;
    if (start && state_q != RUN) begin
      state_d = RUN;
      cnt_d   = '0;
      err_d   = '0;
      idx_d   = '0;
      vec_d   = '0;
      cov_d   = '0;
    end else if (accept) begin
      cnt_d          = cnt_q + 1'b1;
      err_d          = (has_err && err_q != '1) ? err_q + 1'b1 : err_q;
      idx_d          = (has_err && err_q == '0) ? cnt_q : idx_q;
      vec_d          = (has_err && err_q == '0) ? mask : vec_q;
      cov_d[{a, b}]  = 1'b1;
      state_d        = (cnt_q == CNT_W'(N_SAMPLES - 1)) ? DONE : RUN;
    end
  end
  // Status flags are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      cov_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cov_q   <= cov_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE;
      pass_q  <= state_d == DONE && err_d == '0;
    end
  end
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign sample_count  = cnt_q;
  assign err_count     = err_q;
  assign first_err_idx = idx_q;
  assign first_err_vec = vec_q;
  assign cov           = cov_q;
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed runs with an end-of-run scoreboard per checker instance
module tb_gate_response_checker;
  typedef struct packed {
    logic        pass;
    logic [15:0] cnt;
    logic [15:0] err;
    logic [15:0] idx;
    logic [6:0]  vec;
    logic [3:0]  cov;
  } res_t;
  logic clk = 0, rst_n, start, start2, valid, a, b, t, u, v, w, x, y, z;
  logic busy, done, pass, busy2, done2, pass2;
  logic [15:0] sample_count, err_count, first_err_idx;
  logic [1:0]  cnt2, err2, idx2;
  logic [6:0]  first_err_vec, vec2;
  logic [3:0]  cov, cov2;
  logic d1p = 0, d2p = 0;
  int checks = 0, failures = 0;
  res_t q1[$], q2[$];
  always #5 clk = ~clk;
  gate_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .a(a), .b(b),
    .t(t), .u(u), .v(v), .w(w), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .pass(pass), .sample_count(sample_count),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_vec(first_err_vec), .cov(cov));
  gate_response_checker #(.N_SAMPLES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .valid(valid), .a(a), .b(b),
    .t(t), .u(u), .v(v), .w(w), .x(x), .y(y), .z(z),
    .busy(busy2), .done(done2), .pass(pass2), .sample_count(cnt2),
    .err_count(err2), .first_err_idx(idx2), .first_err_vec(vec2), .cov(cov2));
  function automatic logic [6:0] ref_vec(logic ia, logic ib);
    return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ia | ib, ia & ib, ~ia};
  endfunction
  function automatic res_t mk(logic p, int c, int e, int i, logic [6:0] m, logic [3:0] cv);
    return '{p, 16'(c), 16'(e), 16'(i), m, cv};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  task automatic cmp_res(string nm, res_t act, res_t e);
    chk({nm, ".pass"}, 32'(act.pass), 32'(e.pass));
    chk({nm, ".sample_count"}, 32'(act.cnt), 32'(e.cnt));
    chk({nm, ".err_count"}, 32'(act.err), 32'(e.err));
    chk({nm, ".first_err_idx"}, 32'(act.idx), 32'(e.idx));
    chk({nm, ".first_err_vec"}, 32'(act.vec), 32'(e.vec));
    chk({nm, ".cov"}, 32'(act.cov), 32'(e.cov));
  endtask
  task automatic no_exp(string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=done_rise required=no_pending_run", nm);
  endtask
  always @(negedge clk) begin
    res_t r;
    if (done && !d1p) begin
      r = '{pass, sample_count, err_count, first_err_idx, first_err_vec, cov};
      if (q1.size() == 0) no_exp("dut1_unexpected_done");
      else cmp_res("dut1", r, q1.pop_front());
    end
    if (busy) chk("dut1_cnt_bound", 32'(sample_count > 16'd10), 0);
    d1p <= done;
  end
  always @(negedge clk) begin
    res_t r;
    if (done2 && !d2p) begin
      r = '{pass2, {14'b0, cnt2}, {14'b0, err2}, {14'b0, idx2}, vec2, cov2};
      if (q2.size() == 0) no_exp("dut2_unexpected_done");
      else cmp_res("dut2", r, q2.pop_front());
    end
    d2p <= done2;
  end
  task automatic smp(logic va, logic ia, logic ib, logic [6:0] m, logic st, logic st2);
    valid = va; a = ia; b = ib; start = st; start2 = st2;
    {z, y, x, w, v, u, t} = ref_vec(ia, ib) ^ m;
    @(posedge clk);
    #1;
    valid = 0; start = 0; start2 = 0;
  endtask
  task automatic chk_zero(string nm);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".pass"}, 32'(pass), 0);
    chk({nm, ".sample_count"}, 32'(sample_count), 0);
    chk({nm, ".err_count"}, 32'(err_count), 0);
    chk({nm, ".first_err_idx"}, 32'(first_err_idx), 0);
    chk({nm, ".first_err_vec"}, 32'(first_err_vec), 0);
    chk({nm, ".cov"}, 32'(cov), 0);
  endtask
  initial begin
    logic [1:0] p;
    rst_n = 1; start = 0; start2 = 0; valid = 0; a = 0; b = 0;
    {z, y, x, w, v, u, t} = '0;
    #1 rst_n = 0;
    #1 chk_zero("reset");
    chk("reset.done2", 32'(done2), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // clean run over all four input pairs
    q1.push_back(mk(1, 10, 0, 0, 7'h00, 4'hf));
    smp(0, 0, 0, 0, 1, 0);
    chk("run1_busy", 32'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      smp(1, i[1], i[0], 0, 0, 0);
      if (i == 8) chk("run1_done_early", 32'(done), 0);
    end
    chk("run1_done", 32'(done), 1);
    chk("run1_busy_low", 32'(busy), 0);
    // z stuck at 0 on the only a=b=1 sample
    q1.push_back(mk(0, 10, 1, 3, 7'h40, 4'hf));
    smp(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      p = (i == 3) ? 2'b11 : 2'(i % 3);
      smp(1, p[1], p[0], (i == 3) ? 7'h40 : 7'h00, 0, 0);
    end
    // two faults, first mask must be kept
    q1.push_back(mk(0, 10, 2, 2, 7'h05, 4'hf));
    smp(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++)
      smp(1, i[1], i[0], (i == 2) ? 7'h05 : (i == 5) ? 7'h30 : 7'h00, 0, 0);
    // start with a faulty valid in DONE: only the clear happens
    smp(1, 1, 1, 7'h7f, 1, 0);
    chk("restart.sample_count", 32'(sample_count), 0);
    chk("restart.err_count", 32'(err_count), 0);
    chk("restart.cov", 32'(cov), 0);
    chk("restart.busy", 32'(busy), 1);
    q1.push_back(mk(1, 10, 0, 0, 7'h00, 4'b0010));
    for (int i = 0; i < 20; i++) begin
      smp(i % 2 == 0, 0, 1, 0, i == 5 || i == 6, 0);
      if (i == 6) chk("gap.sample_count_after_start", 32'(sample_count), 4);
      if (i == 16) chk("gap.done_early", 32'(done), 0);
      if (i == 18) chk("gap.done", 32'(done), 1);
    end
    chk("gap.sample_count_hold", 32'(sample_count), 10);
    // reset mid-run discards the partial run
    q1.push_back(mk(1, 10, 0, 0, 7'h00, 4'b0100));
    smp(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) smp(1, 1, 0, (i == 1) ? 7'h01 : 7'h00, 0, 0);
    chk("prereset.first_err_idx", 32'(first_err_idx), 1);
    #2 rst_n = 0;
    #1 chk_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1;
    smp(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) smp(1, 1, 0, 0, 0, 0);
    // narrow counters: every sample wrong
    q2.push_back(mk(0, 3, 3, 0, 7'h7f, 4'b0111));
    smp(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      smp(1, i == 2, i == 1, 7'h7f, 0, 0);
      if (i == 1) chk("dut2_done_early", 32'(done2), 0);
    end
    chk("dut2_done", 32'(done2), 1);
    chk("dut1_hold_done", 32'(done), 1);
    chk("dut1_hold_count", 32'(sample_count), 10);
    repeat (3) @(posedge clk);
    #1;
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable scoreboard that sits at the far end of the basic-gates experiment. A stimulus source drives `a`/`b`. The device under test returns the seven gate outputs `t`..`z`. This block recomputes the expected outputs, compares them with the returned ones each accepted cycle, and accumulates error, coverage and first-failure information over a run of `N_SAMPLES` samples. At the end it reports pass/fail so the experiment self-checks on hardware as well as in simulation.

## Interface
Parameters:
- `N_SAMPLES`, 10, number of samples per run; legal range 1 .. 2^CNT_W−1.
- `CNT_W`, 16, width of sample and error counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  pulse; begins a run from IDLE or DONE.
- `valid`  in  1  current `a`, `b`, `t`..`z` form one sample.
- `a`, `b`  in  1 each  stimulus applied to the gates.
- `t`, `u`, `v`, `w`, `x`, `y`, `z`  in  1 each  gate outputs: `t`=NOT a, `u`=AND, `v`=OR, `w`=NAND, `x`=NOR, `y`=XOR, `z`=XNOR.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (level).
- `pass`  out  1  `done` and `err_count`==0.
- `sample_count`  out  CNT_W  samples accepted this run.
- `err_count`  out  CNT_W  samples with ≥1 mismatching gate; saturating.
- `first_err_idx`  out  CNT_W  `sample_count` value at first failing sample.
- `first_err_vec`  out  7  mismatch mask of first failing sample, bit0=`t` … bit6=`z`.
- `cov`  out  4  bit {a,b} set once that input pair has been accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the edge that accepts sample number `N_SAMPLES`.
  - DONE → RUN on `start`.
  - No other transitions.
- `start` in RUN is ignored. `valid` outside RUN is ignored.
- Entering RUN clears `sample_count`, `err_count`, `first_err_*` and `cov` on the same edge.
- Accepted sample: `valid`=1 while state is RUN.
  - Expected vector comes from `a`, `b`.
  - Mismatch mask = expected XOR {z,y,x,w,v,u,t}.
  - `sample_count` increments by 1.
  - `err_count` increments if the mask ≠ 0, saturating at all-ones.
  - The `cov[{a,b}]` bit is set.
- First failure: if the mask ≠ 0 and no error has yet been recorded this run, `first_err_idx` ← pre-increment `sample_count` and `first_err_vec` ← mask.
  - Later failures never overwrite these.
  - With no failure they stay 0.
- Results hold stable in DONE until the next `start` or reset.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`=0; all counters, `first_err_*` and `cov` =0.
- Latency: a sample accepted at edge k is reflected in all outputs immediately after edge k. The comparison is registered directly and there is one flop stage.
- The final sample's effect and `done`=1 / `busy`=0 appear after the same edge.
- `valid` may be held high continuously: one sample per cycle, no back-pressure.
- `valid` gaps in RUN simply stall counting; there is no timeout.
- Reset asserted mid-run returns everything to reset values asynchronously. The partial run is discarded.
- `start` in DONE coincident with nothing else: counters clear and the next cycle's `valid` is sample 0.
- `start` and `valid` in the same IDLE/DONE cycle: only the clear happens; that `valid` is not counted.

## Structure
- Package `gate_chk_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - gate index constants (`G_NOT`=0 … `G_XNOR`=6);
  - `N_GATES`=7.
- Sub-module `gate_ref_model`: purely combinational, inputs `a`, `b`, output 7-bit expected vector in package bit order. It is reused by future gate experiments.
- Top holds the FSM, counters and capture registers.

## Test plan
- Correct DUT model, `N_SAMPLES`=10, all four {a,b} pairs driven → after 10th accept `done`=1, `pass`=1, `err_count`=0, `cov`=4'b1111, `first_err_vec`=0.
- `z` stuck at 0, inputs a=1,b=1 at sample 3 only, otherwise correct → `err_count`=1, `first_err_idx`=3, `first_err_vec`=7'b1000000, `pass`=0.
- Two faults at samples 2 and 5 with different masks → `err_count`=2, `first_err_idx`=2, mask from sample 2 retained.
- `valid` toggling 1,0,1,0 with `start` pulsed again mid-RUN → `start` ignored; `done` only after 10 `valid`-high cycles; `sample_count` never exceeds 10.
- `rst_n` low after 4 samples then released, then `start` → all outputs 0 during reset; new run counts from 0 and completes normally.
- `CNT_W`=2, `N_SAMPLES`=3, every sample wrong → `err_count`=3 (saturation boundary), `done` after 3 accepts.
